// File: rtl/random_lfsr_gen_pkg.sv
// Shared types and helpers for the multi-channel LFSR random source:
// FSM state encoding, Galois tap masks for widths 8..32 and per-channel seed derivation.
package random_lfsr_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_e;

  localparam logic [31:0] SEED_MIX = 32'h0000_9E37;

  function automatic logic [31:0] width_mask(input int width);
    if (width >= 32) begin
      return 32'hFFFF_FFFF;
    end else begin
      return (32'd1 << width) - 32'd1;
    end
  endfunction

  // Right-shifting Galois feedback masks, maximal length for each width.
  function automatic logic [31:0] taps(input int width);
    case (width)
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_B400;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_00B8;
    endcase
  endfunction

  // Channel seed: base xor a per-channel multiple of the mix constant; never zero.
  function automatic logic [31:0] chseed(input logic [31:0] s, input int unsigned c, input int width);
    logic [31:0] r;
    r = (s ^ ((c + 32'd1) * SEED_MIX)) & width_mask(width);
    if (r == 32'd0) begin
      r = 32'd1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/random_lfsr_gen_if.sv
// Request/result bundle between a consumer (master) and random_lfsr_gen (slave).
interface random_lfsr_gen_if #(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 2,
  parameter int OUT_W  = 4
);
  logic                    seed_load;
  logic [WIDTH-1:0]        seed_in;
  logic                    req;
  logic                    busy;
  logic                    valid;
  logic [NUM_CH*OUT_W-1:0] out;

  modport master (output seed_load, seed_in, req, input busy, valid, out);
  modport slave  (input seed_load, seed_in, req, output busy, valid, out);
endinterface

// File: rtl/random_lfsr_gen_ch.sv
// One random channel: Galois LFSR with zero-state guard, rejection sampling into
// [0, RANGE-1] with a wrap-around fallback on the final try, and an accepted flag.
module random_lfsr_gen_ch
  import random_lfsr_gen_pkg::*;
#(
  parameter int          WIDTH = 16,
  parameter int          OUT_W = 4,
  parameter int          RANGE = 16,
  parameter int unsigned CH    = 0,
  parameter logic [31:0] SEED  = 32'h0000_ACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_base,
  input  logic             clr_acc,
  input  logic             draw,
  input  logic             last,
  input  logic             free_step,
  output logic             acc_next,
  output logic [OUT_W-1:0] out_slot
);

  localparam logic [WIDTH-1:0] TAP_MASK = WIDTH'(taps(WIDTH));
  localparam logic [WIDTH-1:0] RST_SEED = WIDTH'(chseed(SEED, CH, WIDTH));
  localparam logic [OUT_W:0]   RANGE_X  = (OUT_W+1)'(RANGE);

  logic [WIDTH-1:0] lfsr_q, lfsr_d, nxt_s;
  logic             acc_q, acc_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [OUT_W:0]   cand_s;
  logic             take_s;

  // A zero state steps to 1, so the guard and the normal step share one path.
  always_comb begin
    if (lfsr_q == {WIDTH{1'b0}}) begin
      nxt_s = WIDTH'(1);
    end else begin
      nxt_s = {1'b0, lfsr_q[WIDTH-1:1]} ^ (lfsr_q[0] ? TAP_MASK : {WIDTH{1'b0}});
    end
    take_s = draw & ~acc_q;
    cand_s = {1'b0, nxt_s[OUT_W-1:0]};
    lfsr_d = lfsr_q;
    acc_d  = acc_q;
    out_d  = out_q;
    if (seed_load) begin
      lfsr_d = WIDTH'(chseed(32'(seed_base), CH, WIDTH));
    end else if (take_s || free_step || (lfsr_q == {WIDTH{1'b0}})) begin
      lfsr_d = nxt_s;
    end else begin
      lfsr_d = lfsr_q;
    end
    if (clr_acc) begin
      acc_d = 1'b0;
    end else if (take_s) begin
      if (cand_s < RANGE_X) begin
        out_d = cand_s[OUT_W-1:0];
        acc_d = 1'b1;
      end else if (last) begin
        out_d = cand_s[OUT_W-1:0] - RANGE_X[OUT_W-1:0];
        acc_d = 1'b1;
      end else begin
        acc_d = 1'b0;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= RST_SEED;
      acc_q  <= 1'b0;
      out_q  <= {OUT_W{1'b0}};
    end else begin
      lfsr_q <= lfsr_d;
      acc_q  <= acc_d;
      out_q  <= out_d;
    end
  end

  assign acc_next = acc_d;
  assign out_slot = out_q;

endmodule

// File: rtl/random_lfsr_gen.sv
// Multi-channel rejection-sampled random source: IDLE/DRAW FSM, tries counter, busy/valid.
// Define RANDOM_FREE_RUN_EN to let every LFSR also step on each IDLE cycle.
module random_lfsr_gen
  import random_lfsr_gen_pkg::*;
#(
  parameter int          WIDTH     = 16,
  parameter int          NUM_CH    = 2,
  parameter int          OUT_W     = 4,
  parameter int          RANGE     = 16,
  parameter int          MAX_TRIES = 8,
  parameter logic [31:0] SEED      = 32'h0000_ACE1
) (
  input logic               clk,
  input logic               reset,
  random_lfsr_gen_if.slave  bus
);

  localparam int            TW       = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES);
  localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

  state_e                  state_q, state_d;
  logic [TW-1:0]           tries_q, tries_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic [NUM_CH-1:0]       acc_next_s;
  logic [NUM_CH*OUT_W-1:0] out_s;
  logic                    idle_s, load_s, start_s, draw_s, last_s, free_s;
  logic [WIDTH-1:0]        seed_base_s;

  // Command decode; seed_load wins over req in the same cycle.
  always_comb begin
    idle_s  = (state_q == IDLE);
    draw_s  = (state_q == DRAW);
    load_s  = idle_s & bus.seed_load;
    start_s = idle_s & ~bus.seed_load & bus.req;
    last_s  = draw_s & (tries_q == LAST_TRY);
    if (bus.seed_in == {WIDTH{1'b0}}) begin
      seed_base_s = WIDTH'(SEED);
    end else begin
      seed_base_s = bus.seed_in;
    end
`ifdef RANDOM_FREE_RUN_EN
    free_s = idle_s;
`else
    free_s = 1'b0;
`endif
  end

  // FSM next state and registered outputs.
  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = DRAW;
          tries_d = {TW{1'b0}};
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      DRAW: begin
        tries_d = tries_q + TW'(1);
        if (&acc_next_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state, counter and handshake registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tries_q <= {TW{1'b0}};
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    random_lfsr_gen_ch #(
      .WIDTH (WIDTH),
      .OUT_W (OUT_W),
      .RANGE (RANGE),
      .CH    (c),
      .SEED  (SEED)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .seed_load (load_s),
      .seed_base (seed_base_s),
      .clr_acc   (load_s | start_s),
      .draw      (draw_s),
      .last      (last_s),
      .free_step (free_s),
      .acc_next  (acc_next_s[c]),
      .out_slot  (out_s[c*OUT_W +: OUT_W])
    );
  end

  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.out   = out_s;

endmodule

// File: tb/tb_random_lfsr_gen.sv
// Scoreboard bench: two instances (RANGE=16/8 tries/2 ch and RANGE=9/2 tries/3 ch)
// checked against an independent Galois LFSR model with hard-coded taps and seed mix.
module tb_random_lfsr_gen;

  typedef struct {
    logic [11:0] out;
    int          vcyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] ms [2][3];
  exp_t        qa[$];
  exp_t        qb[$];
  logic [11:0] first_a;
  logic [11:0] tmp_o;

  random_lfsr_gen_if #(.WIDTH(16), .NUM_CH(2), .OUT_W(4)) ia ();
  random_lfsr_gen_if #(.WIDTH(16), .NUM_CH(3), .OUT_W(4)) ib ();

  random_lfsr_gen #(.WIDTH(16), .NUM_CH(2), .OUT_W(4), .RANGE(16), .MAX_TRIES(8),
                    .SEED(32'h0000_ACE1)) dut_a (.clk(clk), .reset(reset), .bus(ia));
  random_lfsr_gen #(.WIDTH(16), .NUM_CH(3), .OUT_W(4), .RANGE(9), .MAX_TRIES(2),
                    .SEED(32'h0000_ACE1)) dut_b (.clk(clk), .reset(reset), .bus(ib));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_step(input logic [15:0] s);
    if (s == 16'h0) return 16'h1;
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] m_seed(input logic [15:0] s, input int c);
    logic [31:0] p;
    logic [15:0] r;
    p = (c + 1) * 32'h9E37;
    r = s ^ p[15:0];
    if (r == 16'h0) r = 16'h1;
    return r;
  endfunction

  task automatic m_load(input logic [15:0] s);
    logic [15:0] b;
    b = (s == 16'h0) ? 16'hACE1 : s;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 3; c++) ms[d][c] = m_seed(b, c);
  endtask

  task automatic m_draw(input int d, input int n, input int rng, input int mt,
                        output logic [11:0] o, output int lat);
    logic [2:0] acc;
    logic [3:0] cand;
    bit         done;
    acc = 3'b0; o = 12'h0; lat = mt; done = 1'b0;
    for (int t = 1; t <= mt && !done; t++) begin
      for (int c = 0; c < n; c++) begin
        if (!acc[c]) begin
          ms[d][c] = m_step(ms[d][c]);
          cand = ms[d][c][3:0];
          if (int'(cand) < rng) begin
            o[c*4 +: 4] = cand; acc[c] = 1'b1;
          end else if (t == mt) begin
            o[c*4 +: 4] = 4'(int'(cand) - rng); acc[c] = 1'b1;
          end
        end
      end
      if (acc == 3'((1 << n) - 1)) begin
        done = 1'b1; lat = t;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ia.valid === 1'b1) begin
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check_eq("a_out", 32'(ia.out), 32'(e.out));
        check_eq("a_valid_cycle", cyc, e.vcyc);
      end else begin
        check_eq("a_valid_unexpected", 32'(ia.valid), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ib.valid === 1'b1) begin
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check_eq("b_out", 32'(ib.out), 32'(e.out));
        check_eq("b_valid_cycle", cyc, e.vcyc);
        for (int c = 0; c < 3; c++) check_eq("b_in_range", 32'(ib.out[c*4 +: 4] < 4'd9), 32'd1);
      end else begin
        check_eq("b_valid_unexpected", 32'(ib.valid), 32'd0);
      end
    end
  end

  // Called at posedge+1; poke drives seed_load/req during the busy cycle, which must be ignored.
  task automatic do_req(input bit poke, output logic [11:0] oa);
    logic [11:0] ob;
    int la, lb, k;
    m_draw(0, 2, 16, 8, oa, la);
    m_draw(1, 3, 9, 2, ob, lb);
    k = cyc + 1;
    qa.push_back('{oa, k + la});
    qb.push_back('{ob, k + lb});
    ia.req = 1'b1; ib.req = 1'b1;
    @(posedge clk); #1;
    check_eq("a_busy_start", 32'(ia.busy), 32'd1);
    check_eq("b_busy_start", 32'(ib.busy), 32'd1);
    ia.req = 1'b0; ib.req = 1'b0;
    if (poke) begin
      ia.seed_load = 1'b1; ib.seed_load = 1'b1;
      ia.seed_in = 16'h1234; ib.seed_in = 16'h1234;
      ia.req = 1'b1; ib.req = 1'b1;
      @(posedge clk); #1;
      ia.seed_load = 1'b0; ib.seed_load = 1'b0;
      ia.req = 1'b0; ib.req = 1'b0;
    end
    for (int i = 0; i < 16 && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
    #1;
    check_eq("draw_done_pending", 32'(qa.size() + qb.size()), 32'd0);
    qa.delete(); qb.delete();
    check_eq("a_busy_end", 32'(ia.busy), 32'd0);
    check_eq("b_busy_end", 32'(ib.busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    ia.req = 1'b0; ia.seed_load = 1'b0; ia.seed_in = 16'h0;
    ib.req = 1'b0; ib.seed_load = 1'b0; ib.seed_in = 16'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    m_load(16'h0);
    check_eq("a_rst_busy", 32'(ia.busy), 32'd0);
    check_eq("a_rst_valid", 32'(ia.valid), 32'd0);
    check_eq("a_rst_out", 32'(ia.out), 32'd0);
    check_eq("b_rst_busy", 32'(ib.busy), 32'd0);
    check_eq("b_rst_valid", 32'(ib.valid), 32'd0);
    check_eq("b_rst_out", 32'(ib.out), 32'd0);

    do_req(1'b0, first_a);
    repeat (5) do_req(1'b0, tmp_o);
    do_req(1'b1, tmp_o);
    do_req(1'b0, tmp_o);

    // Reset one edge into DRAW aborts the draw.
    ia.req = 1'b1; ib.req = 1'b1;
    @(posedge clk); #1;
    ia.req = 1'b0; ib.req = 1'b0;
    check_eq("a_busy_before_abort", 32'(ia.busy), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("a_abort_busy", 32'(ia.busy), 32'd0);
    check_eq("a_abort_out", 32'(ia.out), 32'd0);
    check_eq("b_abort_busy", 32'(ib.busy), 32'd0);
    check_eq("b_abort_out", 32'(ib.out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_load(16'h0);
    do_req(1'b0, tmp_o);
    check_eq("a_repro_after_reset", 32'(ia.out), 32'(first_a));
    repeat (3) do_req(1'b0, tmp_o);

    // seed_in = 0 restores the reset seed.
    ia.seed_load = 1'b1; ib.seed_load = 1'b1; ia.seed_in = 16'h0; ib.seed_in = 16'h0;
    @(posedge clk); #1;
    ia.seed_load = 1'b0; ib.seed_load = 1'b0;
    m_load(16'h0);
    do_req(1'b0, tmp_o);
    check_eq("a_repro_after_reload", 32'(ia.out), 32'(first_a));
    repeat (3) do_req(1'b0, tmp_o);

    // seed_load and req together: load happens, draw is dropped.
    ia.seed_load = 1'b1; ib.seed_load = 1'b1; ia.seed_in = 16'h5A5A; ib.seed_in = 16'h5A5A;
    ia.req = 1'b1; ib.req = 1'b1;
    @(posedge clk); #1;
    ia.seed_load = 1'b0; ib.seed_load = 1'b0; ia.req = 1'b0; ib.req = 1'b0;
    m_load(16'h5A5A);
    check_eq("a_load_req_busy", 32'(ia.busy), 32'd0);
    check_eq("b_load_req_busy", 32'(ib.busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    repeat (4) do_req(1'b0, tmp_o);

    // Seed whose channel-0 mix is zero: that channel must start from 1.
    ia.seed_load = 1'b1; ib.seed_load = 1'b1; ia.seed_in = 16'h9E37; ib.seed_in = 16'h9E37;
    @(posedge clk); #1;
    ia.seed_load = 1'b0; ib.seed_load = 1'b0;
    m_load(16'h9E37);
    repeat (4) do_req(1'b0, tmp_o);

    repeat (40) do_req(1'b0, tmp_o);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
